// File: rtl/dfp_resp_pkg.sv
// dfp_resp_pkg: shared types and widths for the DFP line responder.
package dfp_resp_pkg;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = 16;
  localparam int LAT_W       = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/dfp_line_ram.sv
// dfp_line_ram: line storage with synchronous write, index-addressed read and synchronous clear.
module dfp_line_ram
  import dfp_resp_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     waddr_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  input  logic [IDX_W-1:0]     raddr_i,
  output logic [LINE_BITS-1:0] rdata_o
);
  logic [LINE_BITS-1:0] mem_q [LINES];
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < LINES; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dfp_line_responder.sv
// dfp_line_responder: fixed-latency line memory responder for a cache DFP port,
// with protocol checking and saturating read/write statistics.
module dfp_line_responder
  import dfp_resp_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int LINES   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic                 proto_err,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count
);
  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [LAT_W-1:0] WAIT_INIT = (LATENCY > 1) ? LAT_W'(LATENCY - 2) : '0;
  state_e                 state_q, state_d;
  logic [LAT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       rdc_q, rdc_d, wrc_q, wrc_d;
  logic [LINE_BITS-1:0]   ram_rdata;
  logic                   enter_resp, mism;
  // Held request must match the latched one exactly until the response.
  assign mism = (dfp_addr != addr_q) || (dfp_read != !wr_q) || (dfp_write != wr_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdc_d   = rdc_q;
    wrc_d   = wrc_q;
    unique case (state_q)
      IDLE: begin
        if (dfp_read && dfp_write) begin
          err_d = 1'b1;
        end else if (dfp_read || dfp_write) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = WAIT_INIT;
          addr_d  = dfp_addr;
          wr_d    = dfp_write;
          wdata_d = dfp_wdata;
          err_d   = err_q | (|dfp_addr[OFFSET_BITS-1:0]);
        end
      end
      WAIT: begin
        err_d   = err_q | mism;
        state_d = (cnt_q == '0) ? RESP : WAIT;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      RESP: begin
        err_d   = err_q | mism;
        state_d = IDLE;
        wrc_d   = (wr_q && wrc_q != '1) ? wrc_q + 1'b1 : wrc_q;
        rdc_d   = (!wr_q && rdc_q != '1) ? rdc_q + 1'b1 : rdc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign rdata_d    = (enter_resp && !wr_d) ? ram_rdata : rdata_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rdc_q   <= '0;
      wrc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdc_q   <= rdc_d;
      wrc_q   <= wrc_d;
    end
  end
  dfp_line_ram #(.LINES(LINES), .IDX_W(IDX_W)) u_ram (
    .clk    (clk),
    .clr_i  (!rst),
    .we_i   (enter_resp && wr_d),
    .waddr_i(addr_d[OFFSET_BITS +: IDX_W]),
    .wdata_i(wdata_d),
    .raddr_i(addr_d[OFFSET_BITS +: IDX_W]),
    .rdata_o(ram_rdata)
  );
  assign dfp_resp  = (state_q == RESP);
  assign dfp_rdata = rdata_q;
  assign proto_err = err_q;
  assign rd_count  = rdc_q;
  assign wr_count  = wrc_q;
endmodule

// File: tb/tb_dfp_line_responder.sv
// tb_dfp_line_responder: directed checks of a LATENCY=4 and a LATENCY=1 responder.
module tb_dfp_line_responder;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr4, addr1;
  logic         rd4, wr4, rd1, wr1;
  logic [255:0] wd4, wd1, rdata4, rdata1;
  logic         resp4, resp1, err4, err1;
  logic [15:0]  rdc4, wrc4, rdc1, wrc1;
  int           n_tests = 0;
  int           n_fail  = 0;
  localparam logic [255:0] PAT_A = {32{8'hA5}};
  localparam logic [255:0] PAT_B = {8{32'h1234_5678}};
  localparam logic [255:0] PAT_D = {16{16'hD00D}};
  localparam logic [255:0] PAT_E = {4{64'hE0E1_E2E3_E4E5_E6E7}};
  localparam logic [255:0] PAT_F = {32{8'h3C}};
  always #5 clk = ~clk;
  dfp_line_responder #(.LATENCY(4), .LINES(16)) u_dut4 (
    .clk(clk), .rst(rst), .dfp_addr(addr4), .dfp_read(rd4), .dfp_write(wr4),
    .dfp_wdata(wd4), .dfp_rdata(rdata4), .dfp_resp(resp4), .proto_err(err4),
    .rd_count(rdc4), .wr_count(wrc4)
  );
  dfp_line_responder #(.LATENCY(1), .LINES(16)) u_dut1 (
    .clk(clk), .rst(rst), .dfp_addr(addr1), .dfp_read(rd1), .dfp_write(wr1),
    .dfp_wdata(wd1), .dfp_rdata(rdata1), .dfp_resp(resp1), .proto_err(err1),
    .rd_count(rdc1), .wr_count(wrc1)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Request issued in cycle 0; resp expected in cycle 4 only; returns in IDLE with request dropped.
  task automatic xact4(input logic w, input logic [31:0] a, input logic [255:0] d);
    rd4 = !w; wr4 = w; addr4 = a; wd4 = d;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("resp4_c%0d", k), resp4, k == 4);
    end
    tick();
    rd4 = 1'b0; wr4 = 1'b0;
    chk("resp4_after", resp4, 1'b0);
  endtask
  task automatic xact1(input logic w, input logic [31:0] a, input logic [255:0] d);
    rd1 = !w; wr1 = w; addr1 = a; wd1 = d;
    tick();
    chk("resp1_c1", resp1, 1'b1);
    tick();
    rd1 = 1'b0; wr1 = 1'b0;
    chk("resp1_c2", resp1, 1'b0);
  endtask
  initial begin
    rst = 1'b0;
    {rd4, wr4, rd1, wr1} = '0;
    addr4 = '0; addr1 = '0; wd4 = '0; wd1 = '0;
    tick(); tick();
    chk("rst_resp", resp4, 1'b0);
    chk("rst_rdata", rdata4, '0);
    chk("rst_err", err4, 1'b0);
    chk("rst_rdc", rdc4, 16'd0);
    chk("rst_wrc", wrc4, 16'd0);
    rst = 1'b1;
    xact4(1'b1, 32'h40, PAT_A);
    chk("wr_cnt1", wrc4, 16'd1);
    chk("rd_cnt0", rdc4, 16'd0);
    xact4(1'b0, 32'h40, '0);
    chk("rd_data_a", rdata4, PAT_A);
    chk("rd_cnt1", rdc4, 16'd1);
    chk("err_clean", err4, 1'b0);
    rd4 = 1'b1; wr4 = 1'b1; addr4 = 32'h80;
    tick();
    chk("both_err", err4, 1'b1);
    rd4 = 1'b0; wr4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("both_noresp", resp4, 1'b0);
      tick();
    end
    chk("both_rdc", rdc4, 16'd1);
    chk("both_wrc", wrc4, 16'd1);
    xact4(1'b1, 32'h20, PAT_B);
    xact4(1'b0, 32'h220, '0);
    chk("alias_data", rdata4, PAT_B);
    chk("alias_rdc", rdc4, 16'd2);
    chk("alias_wrc", wrc4, 16'd2);
    wr4 = 1'b1; addr4 = 32'h60; wd4 = PAT_F;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("abort_resp", resp4, 1'b0);
    chk("abort_err", err4, 1'b0);
    chk("abort_wrc", wrc4, 16'd0);
    rst = 1'b1; wr4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_noresp", resp4, 1'b0);
    end
    xact4(1'b1, 32'h80, PAT_D);
    xact4(1'b0, 32'h80, '0);
    chk("post_rst_d", rdata4, PAT_D);
    xact4(1'b0, 32'h60, '0);
    chk("abort_line_zero", rdata4, '0);
    chk("abort_err_clean", err4, 1'b0);
    rd4 = 1'b1; addr4 = 32'h80;
    tick();
    addr4 = 32'h60;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("chg_resp_c%0d", k), resp4, k == 4);
    end
    chk("chg_latched", rdata4, PAT_D);
    chk("chg_err", err4, 1'b1);
    tick();
    rd4 = 1'b0;
    tick();
    chk("err_sticky", err4, 1'b1);
    xact1(1'b1, 32'h40, PAT_E);
    wr1 = 1'b1; addr1 = 32'h60; wd1 = PAT_F;
    tick();
    chk("b2b_c1", resp1, 1'b1);
    tick();
    chk("b2b_c2", resp1, 1'b0);
    wr1 = 1'b0; rd1 = 1'b1; addr1 = 32'h40;
    tick();
    chk("b2b_c3", resp1, 1'b1);
    chk("b2b_data", rdata1, PAT_E);
    tick();
    rd1 = 1'b0;
    chk("b2b_c4", resp1, 1'b0);
    chk("b2b_wrc", wrc1, 16'd2);
    chk("b2b_rdc", rdc1, 16'd1);
    chk("b2b_err", err1, 1'b0);
    xact1(1'b0, 32'h61, '0);
    chk("misalign_data", rdata1, PAT_F);
    chk("misalign_err", err1, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dfp_line_responder.md
DFP_LINE_RESPONDER -- requirements
Module: dfp_line_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, cycles from request sample to resp (legal 1..15).
REQ-002 The block SHALL have parameter LINES, default 16, number of 256-bit lines stored (power of 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-005 dfp_addr  input  32  line address from cache; bits [4:0] expected zero.
REQ-006 dfp_read  input  1  line read request, held until resp.
REQ-007 dfp_write  input  1  line write request, held until resp.
REQ-008 dfp_wdata  input  256  write line data, held with dfp_write.
REQ-009 dfp_rdata  output  256  read line data, valid in resp cycle.
REQ-010 dfp_resp  output  1  one-cycle completion pulse.
REQ-011 proto_err  output  1  sticky protocol-violation flag.
REQ-012 rd_count  output  16  saturating count of completed reads.
REQ-013 wr_count  output  16  saturating count of completed writes.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-015 In IDLE, exactly one of dfp_read/dfp_write high at an edge SHALL latch address, op and wdata and leave IDLE (to RESP if LATENCY=1, else WAIT).
REQ-016 Request first high in cycle 0 SHALL produce dfp_resp high in exactly cycle LATENCY, for one cycle only.
REQ-017 WAIT SHALL last LATENCY-1 cycles via a down-counter, then go to RESP.
REQ-018 RESP SHALL always go to IDLE on the next edge; a request present in the following cycle SHALL be accepted normally (back-to-back writeback then fill supported).
REQ-019 Line index SHALL be dfp_addr[4+log2(LINES):5]; higher bits ignored (address aliasing wraps).
REQ-020 Write data SHALL be committed to storage on the edge entering RESP.
REQ-021 Read data SHALL be loaded into dfp_rdata on the edge entering RESP and held until the next read completes.
REQ-022 A read following a write to the same line SHALL return the written data.
REQ-023 dfp_read and dfp_write both high in IDLE SHALL set proto_err, not start a transaction, remain IDLE.
REQ-024 dfp_addr[4:0] nonzero at acceptance SHALL set proto_err; transaction proceeds with bits ignored.
REQ-025 During WAIT/RESP, a change of dfp_addr or op, or request dropping before resp, SHALL set proto_err; latched values are used and the transaction completes.
REQ-026 rd_count/wr_count SHALL increment on the edge leaving RESP and saturate at 16'hFFFF.
REQ-027 proto_err SHALL clear only on reset.

Reset
REQ-028 While rst=0 at an edge: state IDLE, counter 0, dfp_resp 0, dfp_rdata 0, proto_err 0, rd_count 0, wr_count 0, all lines zero.
REQ-029 Reset in WAIT or RESP SHALL abort the transaction; a pending write SHALL NOT be committed and no resp SHALL be issued.
REQ-030 Requests present in the first cycle after reset release SHALL be accepted as in IDLE.

Structure
REQ-031 Package dfp_resp_pkg SHALL hold the state enum, LINE_BITS=256, OFFSET_BITS=5, and the counter width.
REQ-032 Line storage SHALL be one sub-module dfp_line_ram (sync write, index-addressed read, synchronous clear).
REQ-033 FSM, latency counter, error checks and statistics counters SHALL live in dfp_line_responder.

Verification
REQ-034 LATENCY=4; write 0x...A5 pattern to 0x00000040 in cycle 0 -> dfp_resp in cycle 4 only; wr_count=1.
REQ-035 Read 0x00000040 in the next cycle -> resp 4 cycles later, dfp_rdata equals written pattern; rd_count=1.
REQ-036 Read and write both high in IDLE -> proto_err=1 next cycle, no dfp_resp ever, counters unchanged.
REQ-037 Write 0x00000020 then read 0x00000220 (LINES=16, aliasing) -> returned data equals written data.
REQ-038 Reset asserted in cycle 2 of a write -> no resp; subsequent read of that line returns all zero.
REQ-039 LATENCY=1; back-to-back write then read to different lines -> resp in cycles 1 and 3, data correct.
